// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline controller: register index type, FSM state and the
// per-cycle enable/flush bundle, plus the rule table for a cycle the memory is not holding.
package pipeline_ctrl_pkg;

    localparam int REG_W_DEF = 5;

    typedef logic [REG_W_DEF-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } pctrl_state_t;

    typedef struct packed {
        logic pc_wen;
        logic ifid_wen;
        logic ifid_flush;
        logic idex_wen;
        logic idex_flush;
        logic exmem_wen;
        logic exmem_flush;
        logic memwb_wen;
    } pctrl_ctl_t;

    localparam pctrl_ctl_t CTL_FREEZE = pctrl_ctl_t'(8'b0000_0000);
    localparam pctrl_ctl_t CTL_RUN    = pctrl_ctl_t'(8'b1101_0101);

    // Priority: taken branch > load-use > jump > fetch miss > free run.
    function automatic pctrl_ctl_t flow_ctl(input logic branch_taken, input logic lu_stall,
                                            input logic jump, input logic ihit);
        pctrl_ctl_t c;
        c = CTL_RUN;
        if (branch_taken) begin
            c.ifid_flush  = 1'b1;
            c.idex_flush  = 1'b1;
            c.exmem_flush = 1'b1;
        end else if (lu_stall) begin
            c.pc_wen     = 1'b0;
            c.ifid_wen   = 1'b0;
            c.idex_flush = 1'b1;
        end else if (jump) begin
            c.ifid_flush = 1'b1;
        end else if (!ihit) begin
            c.pc_wen     = 1'b0;
            c.ifid_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and register-control outputs between datapath (master) and controller (slave).
// stall_count exists only when PIPELINE_CTRL_PERF_EN is defined.
interface pipeline_ctrl_if #(
    parameter int REG_W       = 5,
    parameter int STALL_CNT_W = 32
);
    logic             ihit;
    logic             dhit;
    logic             mem_dren;
    logic             mem_dwen;
    logic             idex_memread;
    logic [REG_W-1:0] idex_rt;
    logic [REG_W-1:0] ifid_rs;
    logic [REG_W-1:0] ifid_rt;
    logic             branch_taken;
    logic             jump;
    logic             halt;
    logic             pc_wen;
    logic             ifid_wen;
    logic             ifid_flush;
    logic             idex_wen;
    logic             idex_flush;
    logic             exmem_wen;
    logic             exmem_flush;
    logic             memwb_wen;
    logic             halted;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [STALL_CNT_W-1:0] stall_count;
`endif

    modport master (
        output ihit, dhit, mem_dren, mem_dwen, idex_memread, idex_rt, ifid_rs, ifid_rt,
        output branch_taken, jump, halt,
        input  pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen, exmem_flush,
        input  memwb_wen, halted
`ifdef PIPELINE_CTRL_PERF_EN
        , input stall_count
`endif
    );

    modport slave (
        input  ihit, dhit, mem_dren, mem_dwen, idex_memread, idex_rt, ifid_rs, ifid_rt,
        input  branch_taken, jump, halt,
        output pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen, exmem_flush,
        output memwb_wen, halted
`ifdef PIPELINE_CTRL_PERF_EN
        , output stall_count
`endif
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use compare: a load in ID/EX whose non-zero destination feeds the instruction in IF/ID.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    output logic             lu_stall
);
    assign lu_stall = idex_memread && (idex_rt != '0) &&
                      ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline write-enable/flush controller (RUN/DWAIT/HALT FSM).
// Optional stall-cycle counter enabled by PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_W       = REG_W_DEF,
    parameter int STALL_CNT_W = 32
) (
    input logic            CLK,
    input logic            RST,
    pipeline_ctrl_if.slave pif
);
    pctrl_state_t state, next_state;
    pctrl_ctl_t   ctl;
    logic         lu_stall;
    logic         mem_busy;
    logic         is_halted;

    if (STALL_CNT_W < 1) begin : g_bad_cnt_w
        $error("STALL_CNT_W must be at least 1");
    end

    hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
        .idex_memread(pif.idex_memread),
        .idex_rt     (pif.idex_rt),
        .ifid_rs     (pif.ifid_rs),
        .ifid_rt     (pif.ifid_rt),
        .lu_stall    (lu_stall)
    );

    assign mem_busy = (pif.mem_dren || pif.mem_dwen) && !pif.dhit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= RUN;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            RUN: begin
                if (pif.halt)    next_state = HALT;
                else if (mem_busy) next_state = DWAIT;
            end
            DWAIT:   if (pif.dhit) next_state = RUN;
            HALT:    next_state = HALT;
            default: next_state = RUN;
        endcase
    end

    // Outputs are forced quiet while RST is high, independent of state.
    always_comb begin
        ctl       = CTL_FREEZE;
        is_halted = 1'b0;
        if (!RST) begin
            case (state)
                RUN: begin
                    if (!pif.halt && !mem_busy)
                        ctl = flow_ctl(pif.branch_taken, lu_stall, pif.jump, pif.ihit);
                end
                DWAIT: begin
                    if (pif.dhit)
                        ctl = flow_ctl(pif.branch_taken, lu_stall, pif.jump, pif.ihit);
                end
                HALT:    is_halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign pif.pc_wen      = ctl.pc_wen;
    assign pif.ifid_wen    = ctl.ifid_wen;
    assign pif.ifid_flush  = ctl.ifid_flush;
    assign pif.idex_wen    = ctl.idex_wen;
    assign pif.idex_flush  = ctl.idex_flush;
    assign pif.exmem_wen   = ctl.exmem_wen;
    assign pif.exmem_flush = ctl.exmem_flush;
    assign pif.memwb_wen   = ctl.memwb_wen;
    assign pif.halted      = is_halted;

`ifdef PIPELINE_CTRL_PERF_EN
    logic [STALL_CNT_W-1:0] stall_cnt;

    // Counts PC-hold cycles outside HALT; sticks at all-ones instead of wrapping.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            stall_cnt <= '0;
        else if ((state != HALT) && !ctl.pc_wen && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

    assign pif.stall_count = stall_cnt;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: rule-table model checked every cycle plus directed literal checks.
// Counter checks are compiled in when PIPELINE_CTRL_PERF_EN is defined.
module tb_pipeline_ctrl;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    // {pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen, exmem_flush, memwb_wen, halted}
    localparam logic [8:0] V_ZERO = 9'b000000000;
    localparam logic [8:0] V_NORM = 9'b110101010;
    localparam logic [8:0] V_LU   = 9'b000111010;
    localparam logic [8:0] V_JMP  = 9'b111101010;
    localparam logic [8:0] V_MISS = 9'b011101010;
    localparam logic [8:0] V_BR   = 9'b111111110;
    localparam logic [8:0] V_HALT = 9'b000000001;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    pipeline_ctrl_if #(.REG_W(5), .STALL_CNT_W(CW)) pif ();

    pipeline_ctrl #(.REG_W(5), .STALL_CNT_W(CW)) dut (
        .CLK(CLK),
        .RST(RST),
        .pif(pif)
    );

    always #5 CLK = ~CLK;

    logic [8:0] dout;
    assign dout = {pif.pc_wen, pif.ifid_wen, pif.ifid_flush, pif.idex_wen, pif.idex_flush,
                   pif.exmem_wen, pif.exmem_flush, pif.memwb_wen, pif.halted};

    // Model: "waiting" = a data access is outstanding, "stopped" = HALT seen.
    logic m_wait = 1'b0;
    logic m_stop = 1'b0;
    int   m_cnt  = 0;
    logic [8:0] exp_now;

    function automatic logic [8:0] model_out(input logic rst, input logic stop, input logic waiting,
                                             input logic ih, input logic dh, input logic dr,
                                             input logic dw, input logic mr, input logic [4:0] rt,
                                             input logic [4:0] rs, input logic [4:0] rt2,
                                             input logic br, input logic jp, input logic hl);
        logic load_use;
        load_use = mr && (rt != 5'd0) && (rt == rs || rt == rt2);
        if (rst)                         return V_ZERO;
        if (stop)                        return V_HALT;
        if (!waiting && hl)              return V_ZERO;
        if (waiting && !dh)              return V_ZERO;
        if (!waiting && (dr || dw) && !dh) return V_ZERO;
        if (br)                          return V_BR;
        if (load_use)                    return V_LU;
        if (jp)                          return V_JMP;
        if (!ih)                         return V_MISS;
        return V_NORM;
    endfunction

    always_comb exp_now = model_out(RST, m_stop, m_wait, pif.ihit, pif.dhit, pif.mem_dren,
                                    pif.mem_dwen, pif.idex_memread, pif.idex_rt, pif.ifid_rs,
                                    pif.ifid_rt, pif.branch_taken, pif.jump, pif.halt);

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_wait <= 1'b0;
            m_stop <= 1'b0;
            m_cnt  <= 0;
        end else begin
            if (!m_stop && !exp_now[8] && m_cnt < CMAX) m_cnt <= m_cnt + 1;
            if (m_stop)           m_stop <= 1'b1;
            else if (m_wait)      m_wait <= !pif.dhit;
            else if (pif.halt)    m_stop <= 1'b1;
            else if ((pif.mem_dren || pif.mem_dwen) && !pif.dhit) m_wait <= 1'b1;
        end
    end

    always @(negedge CLK) begin
        checks++;
        if (dout !== exp_now) begin
            failures++;
            $display("FAIL model_cycle t=%0t: got %b expected %b", $time, dout, exp_now);
        end
`ifdef PIPELINE_CTRL_PERF_EN
        checks++;
        if (pif.stall_count !== CW'(m_cnt)) begin
            failures++;
            $display("FAIL model_stall_count t=%0t: got %0d expected %0d", $time, pif.stall_count, m_cnt);
        end
`endif
    end

    task automatic chk(input string name, input logic [8:0] exp);
        checks++;
        if (dout !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, dout, exp);
        end
    endtask

`ifdef PIPELINE_CTRL_PERF_EN
    task automatic chk_cnt(input string name, input int exp);
        checks++;
        if (pif.stall_count !== CW'(exp)) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, pif.stall_count, exp);
        end
    endtask
`endif

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic drv(input logic ih, input logic dh, input logic dr, input logic dw,
                       input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                       input logic [4:0] rt2, input logic br, input logic jp, input logic hl);
        pif.ihit = ih;         pif.dhit = dh;
        pif.mem_dren = dr;     pif.mem_dwen = dw;
        pif.idex_memread = mr; pif.idex_rt = rt;
        pif.ifid_rs = rs;      pif.ifid_rt = rt2;
        pif.branch_taken = br; pif.jump = jp;
        pif.halt = hl;
    endtask

    task automatic idle();
        drv(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    endtask

    initial begin
        idle();
        repeat (2) cyc();
        #2 chk("reset_outputs", V_ZERO);
        cyc(); RST = 1'b0;
        #2 chk("run_after_reset", V_NORM);

        cyc(); drv(1, 0, 0, 0, 1, 5'd8, 5'd8, 5'd3, 0, 0, 0);
        #2 chk("load_use_rs", V_LU);
        cyc(); drv(1, 0, 0, 0, 1, 5'd8, 5'd3, 5'd8, 0, 0, 0);
        #2 chk("load_use_rt", V_LU);
        cyc(); drv(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        #2 chk("load_use_r0", V_NORM);
        cyc(); drv(1, 0, 0, 0, 0, 5'd8, 5'd8, 5'd8, 0, 0, 0);
        #2 chk("no_load_no_stall", V_NORM);
        cyc(); drv(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        #2 chk("fetch_miss", V_MISS);
        cyc(); drv(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
        #2 chk("jump", V_JMP);

        cyc(); drv(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        #2 chk("dwait_enter", V_ZERO);
        cyc(); #2 chk("dwait_hold1", V_ZERO);
        cyc(); #2 chk("dwait_hold2", V_ZERO);
        cyc(); pif.dhit = 1'b1;
        #2 chk("dwait_release", V_NORM);
        cyc(); idle();
        #2 chk("after_dwait", V_NORM);

        cyc(); drv(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
        #2 chk("store_wait", V_ZERO);
        cyc(); pif.dhit = 1'b1;
        #2 chk("store_release_jump", V_JMP);

        cyc(); drv(1, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 1, 0, 0);
        #2 chk("branch_over_load_use", V_BR);
        cyc(); drv(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0);
        #2 chk("branch_mem_busy", V_ZERO);
        cyc(); pif.dhit = 1'b1;
        #2 chk("branch_on_release", V_BR);

        cyc(); drv(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        cyc();
        #2 RST = 1'b1;
        #1 chk("reset_mid_dwait", V_ZERO);
        cyc(); RST = 1'b0; idle();
        #2 chk("run_after_async_reset", V_NORM);

        cyc(); pif.halt = 1'b1;
        #2 chk("halt_in_run", V_ZERO);
        for (int i = 0; i < 10; i++) begin
            cyc();
            drv(logic'(i & 1), logic'((i >> 1) & 1), logic'((i >> 2) & 1), 0, 0,
                5'd0, 5'd0, 5'd0, logic'((i >> 1) & 1), logic'(i & 1), 0);
            #2 chk("halted_absorbing", V_HALT);
        end
        cyc(); idle(); RST = 1'b1;
        #2 chk("reset_from_halt", V_ZERO);
        cyc(); RST = 1'b0;
        #2 chk("run_after_halt", V_NORM);

`ifdef PIPELINE_CTRL_PERF_EN
        cyc(); RST = 1'b1;
        cyc(); RST = 1'b0; idle();
        #2 chk_cnt("cnt_after_reset", 0);
        cyc(); drv(1, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0);
        cyc();
        cyc(); drv(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        cyc();
        cyc();
        cyc(); pif.dhit = 1'b1;
        #2 chk_cnt("cnt_lu2_dwait3", 5);
        cyc(); pif.ihit = 1'b0; pif.dhit = 1'b0; pif.mem_dren = 1'b0;
        repeat (12) cyc();
        pif.ihit = 1'b1;
        #2 chk_cnt("cnt_saturate", CMAX);
        cyc(); pif.ihit = 1'b0;
        cyc(); pif.ihit = 1'b1;
        #2 chk_cnt("cnt_no_wrap", CMAX);
`endif

        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
